mem_stage_pipe_param: RTL and testbench

//   Parametrised MEM stage of the pipelined RISC-V core: data memory, registered MEM/WB outputs, branch decision.

---
 rtl/mem_stage_pipe_param.sv | 168 ++++++++++++++++
 tb/tb_mem_stage_pipe_param.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_pipe_param.sv
// MEM stage: data memory with B/H/W access, MEM/WB output registers, branch decision, wait-state stall.
// Optional macro MEM_MISALIGN_TRAP_EN: flag misaligned H/W accesses instead of force-aligning them.
module mem_stage_pipe_param #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 64,
  parameter int MEM_LATENCY = 0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush_in,
  input  logic [2:0]      control_M_in,
  input  logic [2:0]      funct3_in,
  input  logic            zero_in,
  input  logic [XLEN-1:0] ALU_result_in,
  input  logic [XLEN-1:0] writeData_in,
  input  logic [1:0]      control_WB_in,
  input  logic [4:0]      rd_in,
  output logic [XLEN-1:0] readData_out,
  output logic [XLEN-1:0] ALU_result_out,
  output logic [1:0]      control_WB_out,
  output logic [4:0]      rd_out,
  output logic            PC_src_out,
  output logic            mem_busy_out,
  output logic            misalign_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state, state_next;
  logic [3:0]      cnt, cnt_next;
  logic            busy, capture, commit;
  logic            mem_read, mem_write, mem_access;
  logic            is_byte, is_half, is_unsigned, misaligned;
  logic [1:0]      lane;
  logic [AW-1:0]   idx;
  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] word, load_data, store_data;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [3:0]      byte_en;
  logic            unused_addr_bits;

  assign mem_read    = control_M_in[1];
  assign mem_write   = control_M_in[0];
  assign mem_access  = mem_read | mem_write;
  assign idx         = ALU_result_in[AW+1:2];
  assign is_byte     = (funct3_in == 3'b000) || (funct3_in == 3'b100);
  assign is_half     = (funct3_in == 3'b001) || (funct3_in == 3'b101);
  assign is_unsigned = funct3_in[2];
  assign unused_addr_bits = ^ALU_result_in[XLEN-1:AW+2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign lane       = ALU_result_in[1:0];
  assign misaligned = mem_access &
                      ((is_half & lane[0]) | (!is_byte & !is_half & (lane != 2'b00)));
`else
  // Undefined funct3 codes fall into the word case and are aligned like W.
  assign lane       = is_byte ? ALU_result_in[1:0] :
                      is_half ? {ALU_result_in[1], 1'b0} : 2'b00;
  assign misaligned = 1'b0;
`endif

  assign word      = mem[idx];
  assign load_byte = word[{lane, 3'b000} +: 8];
  assign load_half = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_data = word;
    if (is_byte)
      load_data = is_unsigned ? {24'b0, load_byte} : {{24{load_byte[7]}}, load_byte};
    else if (is_half)
      load_data = is_unsigned ? {16'b0, load_half} : {{16{load_half[15]}}, load_half};
  end

  always_comb begin
    store_data = writeData_in;
    byte_en    = 4'b1111;
    if (is_byte) begin
      store_data = {4{writeData_in[7:0]}};
      byte_en    = 4'b0001 << lane;
    end else if (is_half) begin
      store_data = {2{writeData_in[15:0]}};
      byte_en    = lane[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Busy drops in the completing cycle so upstream advances on the same edge we capture.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy       = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_access && (LAT != 4'd0) && !flush_in && !misaligned) begin
          state_next = S_WAIT;
          cnt_next   = LAT;
          busy       = 1'b1;
        end else begin
          capture = 1'b1;
        end
      end
      S_WAIT: begin
        if (flush_in || (cnt == 4'd1)) begin
          capture    = 1'b1;
          state_next = S_IDLE;
          cnt_next   = 4'd0;
        end else begin
          busy     = 1'b1;
          cnt_next = cnt - 4'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  assign commit       = capture & mem_write & !flush_in & !misaligned;
  assign mem_busy_out = busy;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      readData_out   <= '0;
      ALU_result_out <= '0;
      control_WB_out <= 2'b00;
      rd_out         <= 5'd0;
      PC_src_out     <= 1'b0;
      misalign_out   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        ALU_result_out <= ALU_result_in;
        if (flush_in) begin
          readData_out   <= '0;
          control_WB_out <= 2'b00;
          rd_out         <= 5'd0;
          PC_src_out     <= 1'b0;
          misalign_out   <= 1'b0;
        end else begin
          readData_out   <= (mem_read && !misaligned) ? load_data : '0;
          control_WB_out <= misaligned ? 2'b00 : control_WB_in;
          rd_out         <= rd_in;
          PC_src_out     <= control_M_in[2] & zero_in;
          misalign_out   <= misaligned;
        end
      end
    end
  end

  // Memory is deliberately left out of reset; a reset edge also blocks any pending commit.
  always_ff @(posedge clock) begin
    if (reset_n && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b])
          mem[idx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_pipe_param.sv
// Bench for mem_stage_pipe_param: a zero-latency and a 3-wait-state instance share held inputs,
// checked against a byte-addressed reference model; honours MEM_MISALIGN_TRAP_EN if defined.
module tb_mem_stage_pipe_param;

  localparam int LAT3 = 3;

  logic        clock = 1'b0;
  logic        reset_n, flush_in, zero_in;
  logic [2:0]  control_M_in, funct3_in;
  logic [31:0] ALU_result_in, writeData_in;
  logic [1:0]  control_WB_in;
  logic [4:0]  rd_in;

  logic [31:0] rdata0, alu0, rdata3, alu3;
  logic [1:0]  wb0, wb3;
  logic [4:0]  rdo0, rdo3;
  logic        pc0, pc3, busy0, busy3, mis0, mis3;

  always #5 clock = ~clock;

  mem_stage_pipe_param #(.XLEN(32), .DEPTH(64), .MEM_LATENCY(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .flush_in(flush_in), .control_M_in(control_M_in),
    .funct3_in(funct3_in), .zero_in(zero_in), .ALU_result_in(ALU_result_in),
    .writeData_in(writeData_in), .control_WB_in(control_WB_in), .rd_in(rd_in),
    .readData_out(rdata0), .ALU_result_out(alu0), .control_WB_out(wb0), .rd_out(rdo0),
    .PC_src_out(pc0), .mem_busy_out(busy0), .misalign_out(mis0));

  mem_stage_pipe_param #(.XLEN(32), .DEPTH(64), .MEM_LATENCY(LAT3)) dut3 (
    .clock(clock), .reset_n(reset_n), .flush_in(flush_in), .control_M_in(control_M_in),
    .funct3_in(funct3_in), .zero_in(zero_in), .ALU_result_in(ALU_result_in),
    .writeData_in(writeData_in), .control_WB_in(control_WB_in), .rd_in(rd_in),
    .readData_out(rdata3), .ALU_result_out(alu3), .control_WB_out(wb3), .rd_out(rdo3),
    .PC_src_out(pc3), .mem_busy_out(busy3), .misalign_out(mis3));

  typedef struct {
    logic        mr, mw, br, zero, flush;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic [1:0]  wb;
    logic [4:0]  rd;
  } op_t;

  typedef struct {
    op_t         op;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] model_mem [256];

  function automatic op_t mk(input logic mr, input logic mw, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] wb, input logic [4:0] rd);
    op_t o;
    o.mr = mr; o.mw = mw; o.br = 1'b0; o.zero = 1'b0; o.flush = 1'b0;
    o.f3 = f3; o.addr = addr; o.wdata = wdata; o.wb = wb; o.rd = rd;
    return o;
  endfunction

  function automatic vec_t mkv(input op_t op, input logic chk, input logic [31:0] exp);
    vec_t v;
    v.op = op; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check2(input string name, input logic [31:0] a0, input logic [31:0] a3,
                        input logic [31:0] exp);
    checkOutput({name, "_lat0"}, a0, exp);
    checkOutput({name, "_lat3"}, a3, exp);
  endtask

  // Byte-level view of the memory: sizes, lanes and extension computed arithmetically.
  task automatic model_step(input op_t op, output logic [31:0] e_data, output logic e_data_vld,
                            output logic [1:0] e_wb, output logic [4:0] e_rd,
                            output logic e_pc, output logic e_mis, output int e_busy);
    int         size, a;
    logic       sgn, mis;
    logic [31:0] v;
    case (op.f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      default:    size = 4;
    endcase
    sgn = (op.f3 == 3'd0) || (op.f3 == 3'd1);
    a   = int'(op.addr[7:0]);
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    if ((op.mr || op.mw) && (a % size) != 0) mis = 1'b1;
`else
    a = a - (a % size);
`endif
    e_data = 32'h0; e_data_vld = 1'b0; e_busy = 0;
    if (op.flush) begin
      e_wb = 2'b00; e_rd = 5'd0; e_pc = 1'b0; e_mis = 1'b0;
      return;
    end
    e_pc   = op.br & op.zero;
    e_rd   = op.rd;
    e_mis  = mis;
    e_wb   = mis ? 2'b00 : op.wb;
    e_busy = ((op.mr || op.mw) && !mis) ? LAT3 : 0;
    if (mis) begin
      e_data_vld = 1'b1;
    end else if (op.mr) begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(model_mem[(a + i) & 255]) << (8 * i));
      if (size < 4 && sgn && v[8*size-1]) v = v | (~32'h0 << (8 * size));
      e_data = v; e_data_vld = 1'b1;
    end else if (op.mw) begin
      for (int i = 0; i < size; i++) model_mem[(a + i) & 255] = op.wdata[8*i +: 8];
    end
  endtask

  task automatic drive(input op_t op);
    control_M_in  = {op.br, op.mr, op.mw};
    zero_in       = op.zero;
    flush_in      = op.flush;
    funct3_in     = op.f3;
    ALU_result_in = op.addr;
    writeData_in  = op.wdata;
    control_WB_in = op.wb;
    rd_in         = op.rd;
  endtask

  // Holds the instruction until the slow instance completes, then lands just after that edge.
  task automatic wait_done(output int busy_cnt, output logic busy0_seen);
    logic done;
    done = 1'b0; busy_cnt = 0; busy0_seen = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clock);
      if (busy0) busy0_seen = 1'b1;
      if (busy3) busy_cnt++;
      else done = 1'b1;
    end
    if (!done) begin
      n_vec++; n_bad++;
      $display("[TB] FAIL timeout: mem_busy_out actual=1 required=0 within 20 cycles");
    end
    @(posedge clock); #1;
  endtask

  task automatic applyStimulus(input op_t op);
    logic [31:0] e_data; logic e_vld, e_pc, e_mis, b0; logic [1:0] e_wb; logic [4:0] e_rd;
    int e_busy, bc;
    drive(op);
    model_step(op, e_data, e_vld, e_wb, e_rd, e_pc, e_mis, e_busy);
    wait_done(bc, b0);
    check2("wb", 32'(wb0), 32'(wb3), 32'(e_wb));
    check2("rd", 32'(rdo0), 32'(rdo3), 32'(e_rd));
    check2("pc_src", 32'(pc0), 32'(pc3), 32'(e_pc));
    check2("misalign", 32'(mis0), 32'(mis3), 32'(e_mis));
    if (!op.flush) check2("alu", alu0, alu3, op.addr);
    if (e_vld) check2("rdata", rdata0, rdata3, e_data);
    checkOutput("busy_cycles_lat3", 32'(bc), 32'(e_busy));
    checkOutput("busy_lat0", 32'(b0), 32'h0);
  endtask

  task automatic check_all_zero(input string name);
    check2({name, "_rdata"}, rdata0, rdata3, 32'h0);
    check2({name, "_alu"}, alu0, alu3, 32'h0);
    check2({name, "_wb"}, 32'(wb0), 32'(wb3), 32'h0);
    check2({name, "_rd"}, 32'(rdo0), 32'(rdo3), 32'h0);
    check2({name, "_pc"}, 32'(pc0), 32'(pc3), 32'h0);
    check2({name, "_mis"}, 32'(mis0), 32'(mis3), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t tbl[$];
    op_t  op;
    int   bc;
    logic b0;
    logic [31:0] tv;

    tv = 32'hABCD0000;
`ifdef MEM_MISALIGN_TRAP_EN
    tv = 32'h0;
`endif
    tbl.push_back(mkv(mk(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 2'b00, 5'd1), 0, 32'h0));
    tbl.push_back(mkv(mk(1, 0, 3'b010, 32'h10, 32'h0, 2'b11, 5'd2), 1, 32'hDEADBEEF));
    tbl.push_back(mkv(mk(0, 1, 3'b010, 32'h10, 32'h44332211, 2'b10, 5'd3), 0, 32'h0));
    tbl.push_back(mkv(mk(0, 1, 3'b000, 32'h11, 32'h12345680, 2'b01, 5'd4), 0, 32'h0));
    tbl.push_back(mkv(mk(1, 0, 3'b000, 32'h11, 32'h0, 2'b11, 5'd5), 1, 32'hFFFFFF80));
    tbl.push_back(mkv(mk(1, 0, 3'b100, 32'h11, 32'h0, 2'b11, 5'd6), 1, 32'h00000080));
    tbl.push_back(mkv(mk(1, 0, 3'b010, 32'h10, 32'h0, 2'b11, 5'd7), 1, 32'h44338011));
    tbl.push_back(mkv(mk(0, 1, 3'b010, 32'h00, 32'h0, 2'b10, 5'd8), 0, 32'h0));
    tbl.push_back(mkv(mk(0, 1, 3'b001, 32'h03, 32'h9999ABCD, 2'b10, 5'd9), 0, 32'h0));
    tbl.push_back(mkv(mk(1, 0, 3'b010, 32'h00, 32'h0, 2'b11, 5'd10), 1, tv));
    tbl.push_back(mkv(mk(1, 0, 3'b101, 32'h02, 32'h0, 2'b11, 5'd11), 1, tv >> 16));
    tbl.push_back(mkv(mk(1, 0, 3'b010, 32'h110, 32'h0, 2'b11, 5'd12), 1, 32'h44338011));
    tbl.push_back(mkv(mk(1, 0, 3'b001, 32'h12, 32'h0, 2'b11, 5'd13), 1, 32'h00004433));
    tbl.push_back(mkv(mk(1, 0, 3'b000, 32'h13, 32'h0, 2'b11, 5'd14), 1, 32'h00000044));

    reset_n = 1'b0;
    drive(mk(0, 0, 3'b000, 32'h0, 32'h0, 2'b00, 5'd0));
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    check2("reset_busy", 32'(busy0), 32'(busy3), 32'h0);
    reset_n = 1'b1;

    for (int w = 0; w < 64; w++)
      applyStimulus(mk(0, 1, 3'b010, 32'(w * 4), $urandom, 2'b00, 5'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].op);
      if (tbl[i].chk) check2($sformatf("table%0d_data", i), rdata0, rdata3, tbl[i].exp);
    end

    // Flush during the wait of a store: only the slow instance must keep the old word.
    applyStimulus(mk(0, 1, 3'b010, 32'h20, 32'h11111111, 2'b00, 5'd0));
    op = mk(0, 1, 3'b010, 32'h20, 32'h22222222, 2'b11, 5'd7);
    op.br = 1'b1; op.zero = 1'b1;
    drive(op);
    @(posedge clock); #1;
    flush_in = 1'b1;
    @(posedge clock); #1;
    check2("flush_wb", 32'(wb0), 32'(wb3), 32'h0);
    check2("flush_rd", 32'(rdo0), 32'(rdo3), 32'h0);
    check2("flush_pc", 32'(pc0), 32'(pc3), 32'h0);
    applyStimulus(mk(0, 0, 3'b000, 32'h1234, 32'h0, 2'b10, 5'd15));
    drive(mk(1, 0, 3'b010, 32'h20, 32'h0, 2'b11, 5'd16));
    wait_done(bc, b0);
    checkOutput("flush_store_kept_lat3", rdata3, 32'h11111111);
    checkOutput("flush_store_done_lat0", rdata0, 32'h22222222);
    applyStimulus(mk(0, 1, 3'b010, 32'h20, 32'h0BADCAFE, 2'b00, 5'd0));

    // Reset arrives in the completing cycle of a slow store.
    applyStimulus(mk(0, 1, 3'b010, 32'h24, 32'h55555555, 2'b00, 5'd0));
    op = mk(0, 1, 3'b010, 32'h24, 32'h66666666, 2'b11, 5'd9);
    op.br = 1'b1; op.zero = 1'b1;
    drive(op);
    repeat (3) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    @(posedge clock); #1;
    check_all_zero("busy_reset");
    reset_n = 1'b1;
    op = mk(0, 0, 3'b000, 32'h8, 32'h0, 2'b01, 5'd3);
    op.br = 1'b1; op.zero = 1'b1;
    applyStimulus(op);
    drive(mk(1, 0, 3'b010, 32'h24, 32'h0, 2'b11, 5'd17));
    wait_done(bc, b0);
    checkOutput("reset_store_blocked_lat3", rdata3, 32'h55555555);
    checkOutput("reset_store_done_lat0", rdata0, 32'h66666666);
    applyStimulus(mk(0, 1, 3'b010, 32'h24, 32'h0, 2'b00, 5'd0));

    for (int n = 0; n < 200; n++) begin
      logic [2:0] ld_f3 [8];
      int kind;
      ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
      kind  = int'($urandom_range(0, 3));
      op = mk(0, 0, ld_f3[$urandom_range(0, 7)], $urandom, $urandom,
              2'($urandom), 5'($urandom));
      if (kind == 1) op.mr = 1'b1;
      if (kind >= 2) begin
        op.mw = 1'b1;
        op.f3 = 3'($urandom_range(0, 2));
      end
      op.br    = 1'($urandom);
      op.zero  = 1'($urandom);
      op.flush = ($urandom_range(0, 7) == 0);
      applyStimulus(op);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
